// File: rtl/lfsr_64_checker.sv
// lfsr_64_checker
//   Checks a serial bit stream produced by the 64-bit Fibonacci LFSR
//   (taps 64,63,61,60, MSB-first, left shift with feedback into bit 0).
//
//   The checker has three states:
//     FILL   : load 64 received bits into the shadow register sr.
//     VERIFY : predict each bit from sr; VERIFY_LEN matches in a row -> LOCKED.
//     LOCKED : keep predicting; ERR_THRESH errors in one WINDOW -> FILL.
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST        : asynchronous active-high reset
//   bit_in     : received serial bit, used only when bit_valid = 1
//   bit_valid  : qualifies bit_in; idle cycles change nothing except error
//   clr_counts : synchronous clear of err_count/bit_count (wins over increment)
//   locked     : registered, 1 while in LOCKED
//   error      : registered one-cycle pulse after a mismatched bit
//   err_count  : registered saturating mismatch count
//   bit_count  : registered saturating count of checked bits
//
// Handshake: there is no back-pressure; a bit is consumed on every rising
// edge where bit_valid = 1, and bit_in is ignored otherwise.
module lfsr_64_checker #(
  parameter int VERIFY_LEN = 64,
  parameter int WINDOW     = 256,
  parameter int ERR_THRESH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clr_counts,
  output logic        locked,
  output logic        error,
  output logic [31:0] err_count,
  output logic [31:0] bit_count
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] VER_LAST = 16'(VERIFY_LEN - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [15:0] ERR_LAST = 16'(ERR_THRESH - 1);

  state_t      state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic [5:0]  fill_cnt_q, fill_cnt_d;
  logic [15:0] ver_cnt_q, ver_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] win_err_q, win_err_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] bit_count_q, bit_count_d;

  logic pred;
  logic mism;
  logic inc_bit;
  logic inc_err;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    ver_cnt_d   = ver_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    error_d     = 1'b0;
    inc_bit     = 1'b0;
    inc_err     = 1'b0;
    pred        = sr_q[63] ^ sr_q[62] ^ sr_q[60] ^ sr_q[59];
    mism        = bit_in ^ pred;

    if (bit_valid) begin
      unique case (state_q)
        FILL: begin
          sr_d = {sr_q[62:0], bit_in};
          if (fill_cnt_q == 6'd63) begin
            fill_cnt_d = 6'd0;
            // An all-zero register is the LFSR lockup state: it would
            // predict zeros forever, so keep filling instead.
            if (sr_d != 64'd0) begin
              state_d   = VERIFY;
              ver_cnt_d = 16'd0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 6'd1;
          end
        end
        VERIFY: begin
          // Shift in the prediction so a corrupted bit cannot poison sr.
          sr_d    = {sr_q[62:0], pred};
          error_d = mism;
          inc_bit = 1'b1;
          inc_err = mism;
          if (mism) begin
            state_d    = FILL;
            fill_cnt_d = 6'd0;
          end else if (ver_cnt_q == VER_LAST) begin
            state_d   = LOCKED;
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end else begin
            ver_cnt_d = ver_cnt_q + 16'd1;
          end
        end
        LOCKED: begin
          sr_d    = {sr_q[62:0], pred};
          error_d = mism;
          inc_bit = 1'b1;
          inc_err = mism;
          if (mism && (win_err_q == ERR_LAST)) begin
            state_d    = FILL;
            fill_cnt_d = 6'd0;
          end else if (win_cnt_q == WIN_LAST) begin
            // Threshold already checked above for this bit; start a new window.
            win_cnt_d = 16'd0;
            win_err_d = 16'd0;
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
            win_err_d = win_err_q + {15'd0, mism};
          end
        end
        default: begin
          state_d    = FILL;
          fill_cnt_d = 6'd0;
        end
      endcase
    end

    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    if (clr_counts) begin
      err_count_d = 32'd0;
      bit_count_d = 32'd0;
    end else begin
      if (inc_bit && (bit_count_q != 32'hFFFF_FFFF)) bit_count_d = bit_count_q + 32'd1;
      if (inc_err && (err_count_q != 32'hFFFF_FFFF)) err_count_d = err_count_q + 32'd1;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= FILL;
      sr_q        <= 64'd0;
      fill_cnt_q  <= 6'd0;
      ver_cnt_q   <= 16'd0;
      win_cnt_q   <= 16'd0;
      win_err_q   <= 16'd0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= 32'd0;
      bit_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      ver_cnt_q   <= ver_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_64_checker.sv
// Directed bench for lfsr_64_checker with default parameters.
module tb_lfsr_64_checker;

  localparam logic [63:0] SEED = 64'hFEEDBABEDEADBEEF;

  logic        CLK;
  logic        RST;
  logic        bit_in;
  logic        bit_valid;
  logic        clr_counts;
  logic        locked;
  logic        error;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  int          n_cmp;
  int          n_bad;
  logic [63:0] gs;   // reference generator state
  int          vc;   // valid bits sent in the gap test

  lfsr_64_checker dut (
    .CLK        (CLK),
    .RST        (RST),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clr_counts (clr_counts),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .bit_count  (bit_count)
  );

  // clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic b, input logic v, input logic c);
    @(negedge CLK);
    bit_in     = b;
    bit_valid  = v;
    clr_counts = c;
    @(posedge CLK);
    #1;
  endtask

  // Next generator bit (MSB first), optionally inverted.
  task automatic send(input logic inv, input logic c);
    logic b;
    b  = gs[63];
    gs = {gs[62:0], gs[63] ^ gs[62] ^ gs[60] ^ gs[59]};
    drive(b ^ inv, 1'b1, c);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST        = 1'b1;
    bit_valid  = 1'b0;
    clr_counts = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    gs         = SEED;
    RST        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    clr_counts = 1'b0;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_count", bit_count, 0);
    @(negedge CLK);
    RST = 1'b0;

    // clean acquisition: 64 fill + 64 verify
    send_n(64);
    chk("fill_bit_count", bit_count, 0);
    chk("fill_locked", locked, 0);
    send_n(63);
    chk("ver127_locked", locked, 0);
    chk("ver127_bit_count", bit_count, 63);
    send(1'b0, 1'b0);
    chk("lock_locked", locked, 1);
    chk("lock_bit_count", bit_count, 64);
    chk("lock_err_count", err_count, 0);
    chk("lock_error", error, 0);

    // single bit error while locked
    send(1'b1, 1'b0);
    chk("err1_error", error, 1);
    chk("err1_err_count", err_count, 1);
    chk("err1_locked", locked, 1);
    chk("err1_bit_count", bit_count, 65);
    send(1'b0, 1'b0);
    chk("err1_pulse_end", error, 0);
    send_n(20);
    chk("err1_after_count", err_count, 1);
    chk("err1_after_locked", locked, 1);

    // finish the first window (256 bits since lock), then clear counters
    send_n(234);
    chk("win_locked", locked, 1);
    send(1'b0, 1'b1);
    chk("clr_bit_count", bit_count, 0);
    chk("clr_err_count", err_count, 0);

    // 7 errors in the fresh window keep lock; the 8th drops it
    for (int k = 0; k < 7; k++) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end
    chk("err7_locked", locked, 1);
    chk("err7_err_count", err_count, 7);
    send(1'b1, 1'b0);
    chk("err8_error", error, 1);
    chk("err8_locked", locked, 0);
    chk("err8_err_count", err_count, 8);
    chk("err8_bit_count", bit_count, 15);

    // reacquire: 64 refill + 64 verify
    send_n(64);
    chk("refill_locked", locked, 0);
    chk("refill_bit_count", bit_count, 15);
    send_n(63);
    chk("reacq127_locked", locked, 0);
    send(1'b0, 1'b0);
    chk("reacq_locked", locked, 1);
    chk("reacq_err_count", err_count, 8);
    chk("reacq_bit_count", bit_count, 79);

    // asynchronous reset in LOCKED while an error pulse is high
    send(1'b1, 1'b0);
    chk("pre_rst_error", error, 1);
    chk("pre_rst_err_count", err_count, 9);
    #2;
    RST       = 1'b1;
    bit_valid = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_error", error, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_bit_count", bit_count, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // 64 zeros leave the checker in FILL, then a full stream locks
    gs = SEED;
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'b0);
    chk("zeros_locked", locked, 0);
    chk("zeros_bit_count", bit_count, 0);
    chk("zeros_error", error, 0);
    send_n(64);
    chk("zfill_bit_count", bit_count, 0);
    send_n(63);
    chk("z127_locked", locked, 0);
    send(1'b0, 1'b0);
    chk("zlock_locked", locked, 1);
    chk("zlock_bit_count", bit_count, 64);

    // clr_counts together with a mismatch
    send(1'b1, 1'b1);
    chk("clrerr_error", error, 1);
    chk("clrerr_err_count", err_count, 0);
    chk("clrerr_bit_count", bit_count, 0);
    chk("clrerr_locked", locked, 1);

    // random valid gaps: lock point counted in valid bits
    do_reset();
    gs = SEED;
    vc = 0;
    for (int i = 0; i < 2000 && vc < 128; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        vc++;
      end else begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      chk("gap_error", error, 0);
      chk("gap_locked", locked, {31'd0, vc >= 128});
      chk("gap_bit_count", bit_count, 32'((vc > 64) ? (vc - 64) : 0));
    end
    chk("gap_final_locked", locked, 1);
    chk("gap_final_err_count", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
